// File: rtl/bcd_updown_counter.sv
// Packed-BCD up/down counter with programmable modulus and validated load.
// Carry/borrow ripples one digit per clock behind a ready handshake.
module bcd_updown_counter #(
    parameter int COUNTER_DIGITS = 6,
    parameter int COUNTER_BITWIDTH = 4 * COUNTER_DIGITS,
    parameter logic [COUNTER_BITWIDTH-1:0] MAX_COUNT = {COUNTER_DIGITS{4'h9}}
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        up,
    input  logic                        load,
    input  logic [COUNTER_BITWIDTH-1:0] loadValue,
    output logic                        ready,
    output logic [COUNTER_BITWIDTH-1:0] countValue,
    output logic                        wrap,
    output logic                        error
);

    localparam int IW = (COUNTER_DIGITS > 1) ? $clog2(COUNTER_DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(COUNTER_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIGIT,
        COMMIT
    } state_t;

    state_t                      state;
    logic [IW-1:0]               idx;
    logic [COUNTER_BITWIDTH-1:0] work;
    logic                        cy;
    logic                        dir;
    logic                        is_load;
    logic                        wrap_hit;
    logic                        bad;

    logic [3:0] nib;
    logic [3:0] nib_next;
    logic       cy_next;
    logic [4:0] sum;

    // Single-nibble step; no adder spans more than one digit.
    always_comb begin
        nib      = work[{idx, 2'b00} +: 4];
        nib_next = nib;
        cy_next  = 1'b0;
        sum      = {1'b0, nib} + {4'b0, cy};
        if (dir) begin
            if (sum > 5'd9) begin
                nib_next = 4'd0;
                cy_next  = 1'b1;
            end else begin
                nib_next = sum[3:0];
            end
        end else begin
            if (cy && nib == 4'd0) begin
                nib_next = 4'd9;
                cy_next  = 1'b1;
            end else begin
                nib_next = nib - {3'b0, cy};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ready      <= 1'b0;
            countValue <= '0;
            wrap       <= 1'b0;
            error      <= 1'b0;
            idx        <= '0;
            work       <= '0;
            cy         <= 1'b0;
            dir        <= 1'b0;
            is_load    <= 1'b0;
            wrap_hit   <= 1'b0;
            bad        <= 1'b0;
        end else begin
            wrap  <= 1'b0;
            error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!ready) begin
                        ready <= 1'b1;
                    end else if (load) begin
                        is_load <= 1'b1;
                        work    <= loadValue;
                        bad     <= 1'b0;
                        idx     <= '0;
                        ready   <= 1'b0;
                        state   <= DIGIT;
                    end else if (enable) begin
                        is_load  <= 1'b0;
                        dir      <= up;
                        work     <= countValue;
                        cy       <= 1'b1;
                        wrap_hit <= up ? (countValue == MAX_COUNT)
                                       : (countValue == '0);
                        idx      <= '0;
                        ready    <= 1'b0;
                        state    <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (is_load) begin
                        bad <= bad | (nib > 4'd9);
                    end else begin
                        work[{idx, 2'b00} +: 4] <= nib_next;
                        cy <= cy_next;
                    end
                    if (idx == LAST) state <= COMMIT;
                    else idx <= idx + 1'b1;
                end
                COMMIT: begin
                    if (is_load) begin
                        if (!bad && work <= MAX_COUNT) countValue <= work;
                        else error <= 1'b1;
                    end else if (wrap_hit) begin
                        countValue <= dir ? '0 : MAX_COUNT;
                        wrap       <= 1'b1;
                    end else begin
                        countValue <= work;
                    end
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: default modulus instance and a
// modulus-60 instance share one stimulus stream.
module tb_bcd_updown_counter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        up = 1'b0;
    logic        load = 1'b0;
    logic [23:0] load_value = '0;

    logic        ready_a, wrap_a, error_a;
    logic [23:0] count_a;
    logic        ready_b, wrap_b, error_b;
    logic [23:0] count_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bcd_updown_counter #(.COUNTER_DIGITS(6)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .load(load), .loadValue(load_value), .ready(ready_a),
        .countValue(count_a), .wrap(wrap_a), .error(error_a)
    );

    bcd_updown_counter #(
        .COUNTER_DIGITS(6),
        .MAX_COUNT(24'h000059)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .up(up),
        .load(load), .loadValue(load_value), .ready(ready_b),
        .countValue(count_b), .wrap(wrap_b), .error(error_b)
    );

    task automatic check(input string tag, input logic [23:0] got,
                         input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one command once both counters are idle; returns at EN+1 +1.
    task automatic do_cmd(input logic l, input logic e, input logic u,
                          input logic [23:0] v);
        int n;
        int low;
        n = 0;
        low = 0;
        while (!(ready_a && ready_b) && n < 40) begin
            tick();
            n++;
        end
        check("ready_wait", {23'b0, ready_a}, 24'h1);
        load = l;
        enable = e;
        up = u;
        load_value = v;
        tick();
        load = 1'b0;
        enable = 1'b0;
        repeat (7) begin
            if (!ready_a) low++;
            tick();
        end
        check("busy_cycles", 24'(low), 24'd7);
    endtask

    initial begin
        int low;
        repeat (3) tick();
        check("rst_ready", {23'b0, ready_a}, 24'h0);
        check("rst_count", count_a, 24'h0);
        reset = 1'b0;
        enable = 1'b1;
        up = 1'b1;
        tick();
        check("ready_rise", {23'b0, ready_a}, 24'h1);
        check("init_count_b", count_b, 24'h0);
        check("init_wrap", {22'b0, wrap_a, error_a}, 24'h0);

        // enable held high: one step per 8 cycles
        for (int k = 1; k <= 10; k++) begin
            low = 0;
            repeat (8) begin
                tick();
                if (!ready_a) low++;
            end
            check("step_count", count_a, (k == 10) ? 24'h10 : 24'(k));
            check("step_low", 24'(low), 24'd7);
        end
        enable = 1'b0;

        do_cmd(1'b1, 1'b0, 1'b0, 24'h999998);
        check("ld_a", count_a, 24'h999998);
        check("ld_a_err", {23'b0, error_a}, 24'h0);
        check("ld_b_err", {23'b0, error_b}, 24'h1);
        check("ld_b_keep", count_b, 24'h000010);

        do_cmd(1'b0, 1'b1, 1'b1, 24'h0);
        check("up_max", count_a, 24'h999999);
        check("up_max_wrap", {23'b0, wrap_a}, 24'h0);
        check("up_b", count_b, 24'h000011);

        do_cmd(1'b0, 1'b1, 1'b1, 24'h0);
        check("wrap_up", count_a, 24'h0);
        check("wrap_up_pulse", {23'b0, wrap_a}, 24'h1);
        check("wrap_up_ready", {23'b0, ready_a}, 24'h1);
        check("wrap_up_b", {23'b0, wrap_b}, 24'h0);
        tick();
        check("wrap_up_fall", {23'b0, wrap_a}, 24'h0);

        do_cmd(1'b1, 1'b0, 1'b0, 24'h0);
        check("ld_zero_b", count_b, 24'h0);

        do_cmd(1'b0, 1'b1, 1'b0, 24'h0);
        check("wrap_dn_b", count_b, 24'h000059);
        check("wrap_dn_b_pulse", {23'b0, wrap_b}, 24'h1);
        check("wrap_dn_a", count_a, 24'h999999);
        check("wrap_dn_a_pulse", {23'b0, wrap_a}, 24'h1);

        do_cmd(1'b0, 1'b1, 1'b0, 24'h0);
        check("dn_b", count_b, 24'h000058);
        check("dn_b_wrap", {23'b0, wrap_b}, 24'h0);
        check("dn_a", count_a, 24'h999998);

        do_cmd(1'b1, 1'b0, 1'b0, 24'h0012A4);
        check("bad_nib_err", {23'b0, error_a}, 24'h1);
        check("bad_nib_keep", count_a, 24'h999998);
        check("bad_nib_wrap", {23'b0, wrap_a}, 24'h0);
        check("bad_nib_b", count_b, 24'h000058);
        tick();
        check("err_fall", {23'b0, error_a}, 24'h0);

        do_cmd(1'b1, 1'b0, 1'b0, 24'h000060);
        check("over_max_err", {23'b0, error_b}, 24'h1);
        check("over_max_keep", count_b, 24'h000058);
        check("over_max_a", count_a, 24'h000060);

        do_cmd(1'b1, 1'b0, 1'b0, 24'h000042);
        check("ld42_b", count_b, 24'h000042);
        check("ld42_err", {23'b0, error_b}, 24'h0);

        do_cmd(1'b1, 1'b1, 1'b1, 24'h000077);
        check("ld_prio", count_a, 24'h000077);

        // requests while busy are dropped
        enable = 1'b1;
        up = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        load = 1'b1;
        enable = 1'b1;
        load_value = 24'h000001;
        tick();
        load = 1'b0;
        enable = 1'b0;
        repeat (5) tick();
        check("busy_ignore", count_a, 24'h000078);
        check("busy_ready", {23'b0, ready_a}, 24'h1);
        repeat (2) tick();
        check("no_queue", count_a, 24'h000078);

        // reset during a count
        do_cmd(1'b1, 1'b0, 1'b0, 24'h000123);
        enable = 1'b1;
        up = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        reset = 1'b1;
        repeat (2) tick();
        check("abort_count", count_a, 24'h0);
        check("abort_wrap", {22'b0, wrap_a, error_a}, 24'h0);
        check("abort_ready", {23'b0, ready_a}, 24'h0);
        reset = 1'b0;
        tick();
        check("abort_ready_rise", {23'b0, ready_a}, 24'h1);
        repeat (8) tick();
        check("abort_stays", count_a, 24'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
